// File: rtl/aes_round_ctrl.sv
// AES round sequencer: out_valid rises 1+NUM_ROUNDS*ROUND_LAT cycles after accept and is held until out_ready.
// Defining AES_ROUND_CTRL_ABORT_EN adds an abort input that drops the in-flight block.
module aes_round_ctrl #(
  parameter int NUM_ROUNDS = 10,
  parameter int ROUND_LAT  = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       load_pt,
  output logic       init_add,
  output logic       state_load,
  output logic [3:0] key_round,
  output logic       last_round,
  output logic       out_valid,
  input  logic       out_ready,
`ifdef AES_ROUND_CTRL_ABORT_EN
  input  logic       abort,
`endif
  output logic       busy
);

  localparam logic [3:0] ROUNDS_W = 4'(NUM_ROUNDS);
  localparam logic [1:0] LAT_LAST = 2'(ROUND_LAT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_INIT  = 2'd1,
    S_ROUND = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t     r_state;
  state_t     w_state_nxt;
  logic [3:0] r_round;
  logic [3:0] w_round_nxt;
  logic [1:0] r_lat;
  logic [1:0] w_lat_nxt;
  logic       w_abort;

`ifdef AES_ROUND_CTRL_ABORT_EN
  assign w_abort = abort;
`else
  assign w_abort = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_round <= 4'd0;
      r_lat   <= 2'd0;
    end else begin
      r_state <= w_state_nxt;
      r_round <= w_round_nxt;
      r_lat   <= w_lat_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_round_nxt = r_round;
    w_lat_nxt   = r_lat;
    in_ready    = 1'b0;
    load_pt     = 1'b0;
    init_add    = 1'b0;
    state_load  = 1'b0;
    key_round   = 4'd0;
    last_round  = 1'b0;
    out_valid   = 1'b0;
    busy        = (r_state != S_IDLE);
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        // Gated so no strobe can leak out while reset is held.
        load_pt  = in_valid & ~rst;
        if (in_valid) begin
          w_state_nxt = S_INIT;
        end
      end
      S_INIT: begin
        init_add    = 1'b1;
        state_load  = 1'b1;
        w_state_nxt = S_ROUND;
        w_round_nxt = 4'd1;
        w_lat_nxt   = 2'd0;
      end
      S_ROUND: begin
        key_round  = r_round;
        last_round = (r_round == ROUNDS_W);
        w_lat_nxt  = r_lat + 2'd1;
        if (r_lat == LAT_LAST) begin
          state_load = 1'b1;
          w_lat_nxt  = 2'd0;
          if (r_round < ROUNDS_W) begin
            w_round_nxt = r_round + 4'd1;
          end else begin
            w_state_nxt = S_DONE;
          end
        end
      end
      S_DONE: begin
        out_valid = 1'b1;
        key_round = ROUNDS_W;
        if (out_ready) begin
          w_state_nxt = S_IDLE;
          w_round_nxt = 4'd0;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
    if (w_abort && (r_state != S_IDLE)) begin
      w_state_nxt = S_IDLE;
      w_round_nxt = 4'd0;
      w_lat_nxt   = 2'd0;
    end
  end

endmodule
